// File: rtl/debug_loader_pkg.sv
// Shared constants and state encoding for the host debug/boot loader.
package debug_pkg;

  // Host command bytes
  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_HALT = 8'h48;  // 'H'
  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
  localparam logic [7:0] CMD_RST  = 8'h58;  // 'X'

  // Response codes
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  // Length of the CPU reset pulse issued by 'X'
  localparam int unsigned CPU_RST_CYCLES = 2;

  // Controller states; encodings kept identical to the legacy localparams
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LEN_HI  = 4'd1,
    ST_LEN_LO  = 4'd2,
    ST_WORD    = 4'd3,
    ST_WRITE   = 4'd4,
    ST_STEP    = 4'd5,
    ST_CAPTURE = 4'd6,
    ST_CPU_RST = 4'd7,
    ST_SEND    = 4'd8
  } state_t;

  // Final response of a load: NAK if any word fell outside the memory
  function automatic logic [7:0] load_rsp(input logic overflow);
    return overflow ? RSP_NAK : RSP_ACK;
  endfunction

endpackage

// File: rtl/debug_tx_shift.sv
// Byte serializer: sends 1..4 bytes of a word MSB-first over valid/ready.
module debug_tx_shift #(
  parameter int unsigned SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [SIZE-1:0] word_i,
  input  logic [2:0]      nbytes_i,
  input  logic            tx_ready_i,
  output logic [7:0]      tx_data_o,
  output logic            tx_valid_o,
  output logic            done_o
);

  logic [SIZE-1:0] sh_q, sh_d;
  logic [2:0]      rem_q, rem_d;
  logic            valid_q, valid_d;
  logic            fire;

  assign fire       = valid_q & tx_ready_i;
  assign tx_data_o  = sh_q[SIZE-1 -: 8];
  assign tx_valid_o = valid_q;
  assign done_o     = fire & (rem_q == 3'd0);

  // Next-state: left-align the payload on load, shift one byte per handshake
  always_comb begin
    sh_d    = sh_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    if (load_i) begin
      sh_d    = word_i << (SIZE - 32'(nbytes_i) * 32'd8);
      rem_d   = nbytes_i - 3'd1;
      valid_d = 1'b1;
    end else if (fire) begin
      if (rem_q == 3'd0) begin
        valid_d = 1'b0;
      end else begin
        sh_d  = sh_q << 8;
        rem_d = rem_q - 3'd1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q    <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/debug_loader.sv
// Host debug/boot controller: loads instruction memory over a byte link and
// controls run/halt/step/reset of the mips pipeline.
module debug_loader
  import debug_pkg::*;
#(
  parameter int unsigned SIZE   = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [SIZE-1:0]   o_imem_data,
  output logic              o_stall,
  output logic              o_cpu_rst,
  input  logic [SIZE-1:0]   i_pc
);

  state_t            state_q, state_d;
  logic              stall_q, stall_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SIZE-1:0]   data_q, data_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       rem_q, rem_d;        // words still to receive
  logic [15:0]       idx_q, idx_d;        // index of the word being received
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       word_q, word_d;      // first three bytes of the word
  logic              ovf_q, ovf_d;
  logic [1:0]        rst_cnt_q, rst_cnt_d;

  logic              tx_load;
  logic [SIZE-1:0]   tx_word;
  logic [2:0]        tx_nbytes;
  logic              tx_done;
  logic              idx_in_range;

  assign idx_in_range = (32'(idx_q) >> ADDR_W) == 32'd0;

  assign o_stall     = stall_q;
  assign o_cpu_rst   = cpu_rst_q;
  assign o_imem_we   = we_q;
  assign o_imem_addr = addr_q;
  assign o_imem_data = data_q;

  debug_tx_shift #(
    .SIZE(SIZE)
  ) u_tx (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tx_load),
    .word_i     (tx_word),
    .nbytes_i   (tx_nbytes),
    .tx_ready_i (i_tx_ready),
    .tx_data_o  (o_tx_data),
    .tx_valid_o (o_tx_valid),
    .done_o     (tx_done)
  );

  // Command decode and load/step/reset sequencing
  always_comb begin
    state_d    = state_q;
    stall_d    = stall_q;
    cpu_rst_d  = cpu_rst_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    len_hi_d   = len_hi_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    ovf_d      = ovf_q;
    rst_cnt_d  = rst_cnt_q;
    tx_load    = 1'b0;
    tx_word    = '0;
    tx_nbytes  = 3'd1;

    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: begin
              stall_d   = 1'b1;
              cpu_rst_d = 1'b1;
              idx_d     = '0;
              ovf_d     = 1'b0;
              state_d   = ST_LEN_HI;
            end
            CMD_RUN: begin
              stall_d = 1'b0;
              tx_load = 1'b1;
              tx_word = SIZE'(RSP_ACK);
              state_d = ST_SEND;
            end
            CMD_HALT: begin
              stall_d = 1'b1;
              tx_load = 1'b1;
              tx_word = SIZE'(RSP_ACK);
              state_d = ST_SEND;
            end
            CMD_STEP: begin
              if (stall_q) begin
                stall_d = 1'b0;
                state_d = ST_STEP;
              end else begin
                tx_load = 1'b1;
                tx_word = SIZE'(RSP_NAK);
                state_d = ST_SEND;
              end
            end
            CMD_RST: begin
              cpu_rst_d = 1'b1;
              stall_d   = 1'b1;
              rst_cnt_d = '0;
              state_d   = ST_CPU_RST;
            end
            default: begin
              tx_load = 1'b1;
              tx_word = SIZE'(RSP_NAK);
              state_d = ST_SEND;
            end
          endcase
        end
      end

      ST_LEN_HI: begin
        if (i_rx_valid) begin
          len_hi_d = i_rx_data;
          state_d  = ST_LEN_LO;
        end
      end

      ST_LEN_LO: begin
        if (i_rx_valid) begin
          if ({len_hi_q, i_rx_data} == 16'd0) begin
            cpu_rst_d = 1'b0;
            tx_load   = 1'b1;
            tx_word   = SIZE'(RSP_ACK);
            state_d   = ST_SEND;
          end else begin
            rem_d      = {len_hi_q, i_rx_data};
            byte_cnt_d = '0;
            state_d    = ST_WORD;
          end
        end
      end

      // The write strobe is registered on the 4th byte so it appears in WRITE
      ST_WORD: begin
        if (i_rx_valid) begin
          word_d     = {word_q[15:0], i_rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (idx_in_range) begin
              we_d   = 1'b1;
              addr_d = ADDR_W'(idx_q);
              data_d = SIZE'({word_q, i_rx_data});
            end else begin
              ovf_d = 1'b1;
            end
            state_d = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        idx_d = idx_q + 16'd1;
        if (rem_q == 16'd1) begin
          cpu_rst_d = 1'b0;
          tx_load   = 1'b1;
          tx_word   = SIZE'(load_rsp(ovf_q));
          state_d   = ST_SEND;
        end else begin
          rem_d   = rem_q - 16'd1;
          state_d = ST_WORD;
        end
      end

      ST_STEP: begin
        stall_d = 1'b1;
        state_d = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        tx_load   = 1'b1;
        tx_word   = i_pc;
        tx_nbytes = 3'd4;
        state_d   = ST_SEND;
      end

      ST_CPU_RST: begin
        if (rst_cnt_q == 2'(CPU_RST_CYCLES - 1)) begin
          cpu_rst_d = 1'b0;
          tx_load   = 1'b1;
          tx_word   = SIZE'(RSP_ACK);
          state_d   = ST_SEND;
        end else begin
          rst_cnt_d = rst_cnt_q + 2'd1;
        end
      end

      ST_SEND: begin
        if (tx_done) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      stall_q    <= 1'b1;
      cpu_rst_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      len_hi_q   <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      ovf_q      <= 1'b0;
      rst_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      stall_q    <= stall_d;
      cpu_rst_q  <= cpu_rst_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      len_hi_q   <= len_hi_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      ovf_q      <= ovf_d;
      rst_cnt_q  <= rst_cnt_d;
    end
  end

endmodule

// File: tb/tb_debug_loader.sv
// Self-checking bench for debug_loader (default instance plus an ADDR_W=1 instance).
`timescale 1ns/1ps
module tb_debug_loader;

  typedef logic [41:0] wr_t;  // {addr[9:0], data[31:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid0 = 1'b0;
  logic        rx_valid1 = 1'b0;
  logic        tx_ready = 1'b1;
  logic [31:0] pc = '0;

  logic [7:0]  tx_data0, tx_data1;
  logic        tx_valid0, tx_valid1, we0, we1;
  logic [9:0]  addr0;
  logic [0:0]  addr1;
  logic [31:0] data0, data1;
  logic        stall0, stall1, cpu_rst0, cpu_rst1;

  int n_cmp = 0;
  int n_err = 0;
  int stall_lo0 = 0;
  int stall_hi0 = 0;
  int cpu_rst_hi0 = 0;

  logic [7:0] obs_tx0[$], obs_tx1[$], exp_tx0[$], exp_tx1[$];
  wr_t        obs_wr0[$], obs_wr1[$], exp_wr0[$], exp_wr1[$];

  always #5 clk = ~clk;

  debug_loader #(.SIZE(32), .ADDR_W(10)) u_dut0 (
    .clk(clk), .rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid0),
    .o_tx_data(tx_data0), .o_tx_valid(tx_valid0), .i_tx_ready(tx_ready),
    .o_imem_we(we0), .o_imem_addr(addr0), .o_imem_data(data0),
    .o_stall(stall0), .o_cpu_rst(cpu_rst0), .i_pc(pc)
  );

  debug_loader #(.SIZE(32), .ADDR_W(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid1),
    .o_tx_data(tx_data1), .o_tx_valid(tx_valid1), .i_tx_ready(tx_ready),
    .o_imem_we(we1), .o_imem_addr(addr1), .o_imem_data(data1),
    .o_stall(stall1), .o_cpu_rst(cpu_rst1), .i_pc(pc)
  );

  // Record what happens at the coming rising edge, then advance one cycle
  task automatic tick();
    if (tx_valid0 === 1'b1 && tx_ready) obs_tx0.push_back(tx_data0);
    if (tx_valid1 === 1'b1 && tx_ready) obs_tx1.push_back(tx_data1);
    if (we0 === 1'b1) obs_wr0.push_back({addr0, data0});
    if (we1 === 1'b1) obs_wr1.push_back({9'd0, addr1, data1});
    if (stall0 === 1'b0) stall_lo0++;
    if (stall0 === 1'b1) stall_hi0++;
    if (cpu_rst0 === 1'b1) cpu_rst_hi0++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int which);
    rx_data = b;
    if (which == 0) rx_valid0 = 1'b1;
    else rx_valid1 = 1'b1;
    tick();
    rx_valid0 = 1'b0;
    rx_valid1 = 1'b0;
  endtask

  task automatic wait_tx(input int which, input int n, output bit ok);
    int c = 0;
    while (((which == 0) ? obs_tx0.size() : obs_tx1.size()) < n && c < 300) begin
      tick();
      c++;
    end
    ok = ((which == 0) ? obs_tx0.size() : obs_tx1.size()) >= n;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    n_cmp++; if (stall0 !== 1'b1) begin n_err++; $display("FAIL reset_stall: got %b want 1", stall0); end
    n_cmp++; if (cpu_rst0 !== 1'b0) begin n_err++; $display("FAIL reset_cpu_rst: got %b want 0", cpu_rst0); end
    n_cmp++; if (tx_valid0 !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid0); end
    n_cmp++; if (tx_data0 !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", tx_data0); end
    n_cmp++; if (we0 !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", we0); end
    n_cmp++; if (addr0 !== 10'd0 || data0 !== 32'd0) begin n_err++; $display("FAIL reset_imem: got %h/%h want 0/0", addr0, data0); end
    n_cmp++; if (stall1 !== 1'b1 || tx_valid1 !== 1'b0 || cpu_rst1 !== 1'b0) begin
      n_err++; $display("FAIL reset_dut1: got stall=%b txv=%b crst=%b want 1/0/0", stall1, tx_valid1, cpu_rst1);
    end
    rst = 1'b0;
    idle(2);
    obs_tx0.delete(); obs_tx1.delete(); obs_wr0.delete(); obs_wr1.delete();
  endtask

  task automatic test_load();
    logic [7:0] seq [11];
    logic [7:0] e, a;
    wr_t        ew, aw;
    bit         ok;
    bit         rst_ok = 1'b1;
    seq = '{8'h4C, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h04};
    exp_wr0.push_back({10'd0, 32'h20080005});
    exp_wr0.push_back({10'd1, 32'hAC010004});
    exp_tx0.push_back(8'h06);
    for (int i = 0; i < 11; i++) begin
      send_byte(seq[i], 0);
      if (cpu_rst0 !== 1'b1) rst_ok = 1'b0;
      idle(2);
    end
    n_cmp++; if (!rst_ok) begin n_err++; $display("FAIL load_cpu_rst_held: got a low cycle want 1 throughout"); end
    wait_tx(0, 1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL load_tx_timeout: got no response want 1 byte"); end
    while (exp_wr0.size() > 0) begin
      ew = exp_wr0.pop_front();
      n_cmp++;
      if (obs_wr0.size() == 0) begin n_err++; $display("FAIL load_write: got none want %h", ew); end
      else begin aw = obs_wr0.pop_front(); if (aw !== ew) begin n_err++; $display("FAIL load_write: got %h want %h", aw, ew); end end
    end
    n_cmp++; if (obs_wr0.size() != 0) begin n_err++; $display("FAIL load_write_extra: got %0d want 0", obs_wr0.size()); obs_wr0.delete(); end
    // zero-length load answers ACK straight away
    exp_tx0.push_back(8'h06);
    send_byte(8'h4C, 0); idle(2);
    send_byte(8'h00, 0); idle(2);
    send_byte(8'h00, 0);
    wait_tx(0, 2, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL load0_tx_timeout: got no response want 1 byte"); end
    while (exp_tx0.size() > 0) begin
      e = exp_tx0.pop_front();
      n_cmp++;
      if (obs_tx0.size() == 0) begin n_err++; $display("FAIL load_tx: got none want %h", e); end
      else begin a = obs_tx0.pop_front(); if (a !== e) begin n_err++; $display("FAIL load_tx: got %h want %h", a, e); end end
    end
    n_cmp++; if (cpu_rst0 !== 1'b0 || stall0 !== 1'b1) begin
      n_err++; $display("FAIL load_end_ctrl: got crst=%b stall=%b want 0/1", cpu_rst0, stall0);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] words [3];
    logic [7:0]  e, a;
    wr_t         ew, aw;
    bit          ok;
    words = '{32'h11111111, 32'h22222222, 32'h33333333};
    exp_wr1.push_back({10'd0, 32'h11111111});
    exp_wr1.push_back({10'd1, 32'h22222222});
    exp_tx1.push_back(8'h15);
    send_byte(8'h4C, 1); idle(2);
    send_byte(8'h00, 1); idle(2);
    send_byte(8'h03, 1); idle(2);
    for (int w = 0; w < 3; w++) begin
      for (int b = 3; b >= 0; b--) begin
        send_byte(words[w][b*8 +: 8], 1);
        idle(2);
      end
    end
    wait_tx(1, 1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ovf_tx_timeout: got no response want 1 byte"); end
    while (exp_wr1.size() > 0) begin
      ew = exp_wr1.pop_front();
      n_cmp++;
      if (obs_wr1.size() == 0) begin n_err++; $display("FAIL ovf_write: got none want %h", ew); end
      else begin aw = obs_wr1.pop_front(); if (aw !== ew) begin n_err++; $display("FAIL ovf_write: got %h want %h", aw, ew); end end
    end
    n_cmp++; if (obs_wr1.size() != 0) begin n_err++; $display("FAIL ovf_write_extra: got %0d want 0", obs_wr1.size()); obs_wr1.delete(); end
    while (exp_tx1.size() > 0) begin
      e = exp_tx1.pop_front();
      n_cmp++;
      if (obs_tx1.size() == 0) begin n_err++; $display("FAIL ovf_tx: got none want %h", e); end
      else begin a = obs_tx1.pop_front(); if (a !== e) begin n_err++; $display("FAIL ovf_tx: got %h want %h", a, e); end end
    end
  endtask

  task automatic test_step();
    logic [7:0] e, a;
    bit         ok;
    bit         stable = 1'b1;
    int         c = 0;
    pc = 32'h00000008;
    tx_ready = 1'b0;
    stall_lo0 = 0;
    send_byte(8'h53, 0);
    n_cmp++; if (stall0 !== 1'b0) begin n_err++; $display("FAIL step_t1_stall: got %b want 0", stall0); end
    tick();
    n_cmp++; if (stall0 !== 1'b1) begin n_err++; $display("FAIL step_t2_stall: got %b want 1", stall0); end
    while (tx_valid0 !== 1'b1 && c < 20) begin tick(); c++; end
    n_cmp++; if (tx_valid0 !== 1'b1) begin n_err++; $display("FAIL step_tx_valid: got %b want 1", tx_valid0); end
    pc = 32'hDEADBEEF;  // must not affect the already captured PC
    repeat (5) begin
      tick();
      if (tx_valid0 !== 1'b1 || tx_data0 !== 8'h00) stable = 1'b0;
    end
    n_cmp++; if (!stable) begin n_err++; $display("FAIL step_hold: got valid=%b data=%h want 1/00 stable", tx_valid0, tx_data0); end
    n_cmp++; if (obs_tx0.size() != 0) begin n_err++; $display("FAIL step_no_ready: got %0d bytes want 0", obs_tx0.size()); end
    exp_tx0.push_back(8'h00); exp_tx0.push_back(8'h00);
    exp_tx0.push_back(8'h00); exp_tx0.push_back(8'h08);
    tx_ready = 1'b1;
    wait_tx(0, 4, ok);
    idle(3);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL step_tx_timeout: got %0d bytes want 4", obs_tx0.size()); end
    while (exp_tx0.size() > 0) begin
      e = exp_tx0.pop_front();
      n_cmp++;
      if (obs_tx0.size() == 0) begin n_err++; $display("FAIL step_tx: got none want %h", e); end
      else begin a = obs_tx0.pop_front(); if (a !== e) begin n_err++; $display("FAIL step_tx: got %h want %h", a, e); end end
    end
    n_cmp++; if (obs_tx0.size() != 0) begin n_err++; $display("FAIL step_tx_extra: got %0d want 0", obs_tx0.size()); obs_tx0.delete(); end
    n_cmp++; if (stall_lo0 != 1) begin n_err++; $display("FAIL step_stall_width: got %0d want 1", stall_lo0); end
  endtask

  task automatic test_run_halt();
    logic [7:0] e, a;
    bit         ok;
    exp_tx0.push_back(8'h06);  // R
    exp_tx0.push_back(8'h06);  // R while running
    exp_tx0.push_back(8'h15);  // S while running
    exp_tx0.push_back(8'h06);  // H
    exp_tx0.push_back(8'h06);  // R
    exp_tx0.push_back(8'h06);  // X
    send_byte(8'h52, 0);
    n_cmp++; if (stall0 !== 1'b0) begin n_err++; $display("FAIL run_stall: got %b want 0", stall0); end
    stall_hi0 = 0;
    wait_tx(0, obs_tx0.size() + 1, ok);
    send_byte(8'h52, 0);
    wait_tx(0, obs_tx0.size() + 1, ok);
    send_byte(8'h53, 0);
    wait_tx(0, obs_tx0.size() + 1, ok);
    n_cmp++; if (stall_hi0 != 0) begin n_err++; $display("FAIL run_stall_cont: got %0d high cycles want 0", stall_hi0); end
    send_byte(8'h48, 0);
    n_cmp++; if (stall0 !== 1'b1) begin n_err++; $display("FAIL halt_stall: got %b want 1", stall0); end
    wait_tx(0, obs_tx0.size() + 1, ok);
    send_byte(8'h52, 0);
    wait_tx(0, obs_tx0.size() + 1, ok);
    cpu_rst_hi0 = 0;
    send_byte(8'h58, 0);
    n_cmp++; if (stall0 !== 1'b1 || cpu_rst0 !== 1'b1) begin
      n_err++; $display("FAIL xrst_start: got stall=%b crst=%b want 1/1", stall0, cpu_rst0);
    end
    wait_tx(0, obs_tx0.size() + 1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL xrst_tx_timeout: got no response want ACK"); end
    n_cmp++; if (cpu_rst_hi0 != 2) begin n_err++; $display("FAIL xrst_width: got %0d want 2", cpu_rst_hi0); end
    while (exp_tx0.size() > 0) begin
      e = exp_tx0.pop_front();
      n_cmp++;
      if (obs_tx0.size() == 0) begin n_err++; $display("FAIL runhalt_tx: got none want %h", e); end
      else begin a = obs_tx0.pop_front(); if (a !== e) begin n_err++; $display("FAIL runhalt_tx: got %h want %h", a, e); end end
    end
  endtask

  task automatic test_unknown_abort();
    logic [7:0] e, a;
    bit         ok;
    exp_tx0.push_back(8'h15);
    send_byte(8'h41, 0);
    wait_tx(0, 1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL unknown_tx_timeout: got no response want NAK"); end
    e = exp_tx0.pop_front();
    n_cmp++;
    if (obs_tx0.size() == 0) begin n_err++; $display("FAIL unknown_tx: got none want %h", e); end
    else begin a = obs_tx0.pop_front(); if (a !== e) begin n_err++; $display("FAIL unknown_tx: got %h want %h", a, e); end end
    // rst lands on the 3rd byte of the only word of a load
    send_byte(8'h4C, 0); idle(2);
    send_byte(8'h00, 0); idle(2);
    send_byte(8'h01, 0); idle(2);
    send_byte(8'h11, 0); idle(2);
    send_byte(8'h22, 0); idle(2);
    rx_data = 8'h33; rx_valid0 = 1'b1; rst = 1'b1;
    tick();
    rx_valid0 = 1'b0; rst = 1'b0;
    idle(20);
    n_cmp++; if (obs_wr0.size() != 0) begin n_err++; $display("FAIL abort_write: got %0d writes want 0", obs_wr0.size()); end
    n_cmp++; if (obs_tx0.size() != 0) begin n_err++; $display("FAIL abort_tx: got %0d bytes want 0", obs_tx0.size()); end
    n_cmp++; if (stall0 !== 1'b1 || cpu_rst0 !== 1'b0) begin
      n_err++; $display("FAIL abort_ctrl: got stall=%b crst=%b want 1/0", stall0, cpu_rst0);
    end
    exp_tx0.push_back(8'h06);
    send_byte(8'h48, 0);
    wait_tx(0, 1, ok);
    e = exp_tx0.pop_front();
    n_cmp++;
    if (obs_tx0.size() == 0) begin n_err++; $display("FAIL abort_idle_tx: got none want %h", e); end
    else begin a = obs_tx0.pop_front(); if (a !== e) begin n_err++; $display("FAIL abort_idle_tx: got %h want %h", a, e); end end
  endtask

  initial begin
    test_reset();
    test_load();
    test_overflow();
    test_step();
    test_run_halt();
    test_unknown_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1);
  end

endmodule
